// File: rtl/eka_fetch_unit.sv
// rtl/eka_fetch_unit.sv - instruction fetch stage between the Eka core and a req/gnt/rvalid memory bus
//
// Purpose: fetches the word at the core PC over a variable-latency memory bus,
// holds it stable while the core is stalled and releases it on retire.
// Optional macro EKA_IFU_PREFETCH_EN adds a one-entry sequential prefetch slot.
//
// Ports:
//   clk          processor clock, rising edge
//   reset        asynchronous active-low reset
//   inst_addr    core PC (word aligned)
//   data_stall   core data stall; retire = inst_valid & !data_stall
//   instruction  instruction word for the core (NOP_INSTR when nothing held)
//   inst_valid   instruction belongs to the current inst_addr
//   imem_req     memory request
//   imem_addr    request address, 0 when imem_req is low
//   imem_gnt     request accepted this cycle
//   imem_rvalid  in-order response valid
//   imem_rdata   response data
module eka_fetch_unit #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic                  data_stall,
   output logic [31:0]           instruction,
   output logic                  inst_valid,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [31:0]           imem_rdata
);

   typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic [ADDR_WIDTH-1:0] buf_addr;
   logic [31:0]           buf_data;
   logic [1:0]            outstanding;
   logic                  issue, resp, take, addr_match, retire;

   assign addr_match = (buf_addr == inst_addr);
   assign retire     = (state == HOLD) && addr_match && !data_stall;
   assign issue      = imem_req && imem_gnt;
   // A response with nothing outstanding (e.g. a late one after reset) is ignored.
   assign resp       = imem_rvalid && (outstanding != 2'd0);

`ifdef EKA_IFU_PREFETCH_EN
   logic [ADDR_WIDTH-1:0] pf_addr;
   logic [31:0]           pf_data;
   logic                  pf_valid, pf_pending;
   logic [1:0]            drop_cnt;   // responses still in flight for abandoned fetches
   logic [ADDR_WIDTH-1:0] next_seq;
   logic                  pf_hit;
   logic [31:0]           pf_word;

   assign next_seq = buf_addr + ADDR_WIDTH'(4);
   assign take     = resp && (drop_cnt == 2'd0);
   // The slot counts as full if its response lands in the retire cycle itself.
   assign pf_hit   = pf_valid || (pf_pending && take);
   assign pf_word  = pf_valid ? pf_data : imem_rdata;
`else
   assign take     = resp;
`endif

   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      imem_addr   = '0;
      inst_valid  = 1'b0;
      instruction = NOP_INSTR;
      case (state)
         REQ: begin
            imem_req  = reset;
            imem_addr = reset ? inst_addr : '0;
            if (reset && imem_gnt) state_next = WAIT;
         end
         WAIT: begin
`ifdef EKA_IFU_PREFETCH_EN
            // A PC change here means the awaited prefetch was for a branch shadow.
            if (inst_addr != fetch_addr) state_next = REQ;
            else if (take) state_next = HOLD;
`else
            if (take) state_next = HOLD;
`endif
         end
         HOLD: begin
            instruction = buf_data;
            inst_valid  = addr_match;
            if (!addr_match) state_next = REQ;
`ifdef EKA_IFU_PREFETCH_EN
            else begin
               if (!pf_valid && !pf_pending) begin
                  imem_req  = 1'b1;
                  imem_addr = next_seq;
               end
               if (retire) begin
                  if (pf_hit) state_next = HOLD;
                  else if (pf_pending || (!pf_valid && imem_gnt)) state_next = WAIT;
                  else state_next = REQ;
               end
            end
`else
            else if (retire) state_next = REQ;
`endif
         end
         default: state_next = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= REQ;
         fetch_addr  <= '0;
         buf_addr    <= '0;
         buf_data    <= NOP_INSTR;
         outstanding <= 2'd0;
`ifdef EKA_IFU_PREFETCH_EN
         pf_addr     <= '0;
         pf_data     <= NOP_INSTR;
         pf_valid    <= 1'b0;
         pf_pending  <= 1'b0;
         drop_cnt    <= 2'd0;
`endif
      end else begin
         state <= state_next;
         case ({issue, resp})
            2'b10:   if (outstanding != 2'd2) outstanding <= outstanding + 2'd1;
            2'b01:   outstanding <= outstanding - 2'd1;
            default: ;
         endcase
         if (state == REQ && issue) fetch_addr <= inst_addr;
         if (state == WAIT && take) begin
            buf_data <= imem_rdata;
            buf_addr <= fetch_addr;
         end
`ifdef EKA_IFU_PREFETCH_EN
         if (resp && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
         if (state == HOLD && pf_pending && take) begin
            pf_data    <= imem_rdata;
            pf_valid   <= 1'b1;
            pf_pending <= 1'b0;
         end
         if (state == HOLD && issue) begin
            pf_pending <= 1'b1;
            pf_addr    <= next_seq;
         end
         // Later assignments below override the slot updates above.
         if (state == HOLD && !addr_match) begin
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
            drop_cnt   <= outstanding - {1'b0, resp};
         end else if (retire) begin
            if (pf_hit) begin
               buf_data <= pf_word;
               buf_addr <= pf_addr;
            end else if (pf_pending || issue) begin
               fetch_addr <= next_seq;
            end
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
         end
         if (state == WAIT && inst_addr != fetch_addr)
            drop_cnt <= outstanding - {1'b0, resp};
`endif
      end
   end

endmodule
